// File: rtl/ripple_pipe_addsub.sv
// Pipelined N-bit ripple-carry add/subtract: STAGES segments of SEG bits, carry registered
// between segments, valid/ready stream handshake with a single global stall.
module ripple_pipe_addsub #(
  parameter int N   = 16,
  parameter int SEG = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int STAGES = N / SEG;

  logic              adv;
  logic [N-1:0]      bp_in;
  logic [N-1:0]      a_q   [STAGES];
  logic [N-1:0]      bp_q  [STAGES];
  logic [N-1:0]      res_q [STAGES];
  logic [N-1:0]      res_d [STAGES];
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] c_d;
  logic              ovf_q;
  logic              ovf_d;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];
  assign sum       = res_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

  // Subtraction folds into the adder as A + ~B + 1.
  assign bp_in = sub ? ~b : b;

  // Stage k ripples segment k; operands of later segments travel along unchanged in a_q/bp_q,
  // and finished lower segments ride along in res_q so the whole word leaves together.
  always_comb begin
    logic [N-1:0] av;
    logic [N-1:0] bv;
    logic [N-1:0] rv;
    logic         c;
    logic         c_top;
    int           p;
    av    = '0;
    bv    = '0;
    rv    = '0;
    c     = 1'b0;
    c_top = 1'b0;
    c_d   = '0;
    ovf_d = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      p = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        av = a;
        bv = bp_in;
        c  = sub | cin;
        rv = '0;
      end else begin
        av = a_q[p];
        bv = bp_q[p];
        c  = c_q[p];
        rv = res_q[p];
      end
      for (int i = 0; i < SEG; i++) begin
        c_top            = c;
        rv[k*SEG + i]    = av[k*SEG + i] ^ bv[k*SEG + i] ^ c;
        c                = (av[k*SEG + i] & bv[k*SEG + i]) | (c & (av[k*SEG + i] ^ bv[k*SEG + i]));
      end
      res_d[k] = rv;
      c_d[k]   = c;
      // c_top is the carry into bit N-1 only once the last segment has rippled.
      if (k == STAGES - 1) ovf_d = c_top ^ c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        bp_q[k]  <= '0;
        res_q[k] <= '0;
      end
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      v_q[0]  <= in_valid;
      a_q[0]  <= a;
      bp_q[0] <= bp_in;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k]  <= v_q[k-1];
        a_q[k]  <= a_q[k-1];
        bp_q[k] <= bp_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) res_q[k] <= res_d[k];
      c_q   <= c_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ripple_pipe_addsub.sv
// Directed and backpressure bench for ripple_pipe_addsub at (16,4), (16,16) and (32,8);
// one instance is exercised at a time and checked against an in-order expectation queue.
module tb_ripple_pipe_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  logic [63:0] a_d [3];
  logic [63:0] b_d [3];
  logic        cin_d [3];
  logic        sub_d [3];
  logic        in_valid_d [3];
  logic        out_ready_d [3];
  wire  [63:0] sum_o [3];
  wire         in_ready_o [3];
  wire         out_valid_o [3];
  wire         cout_o [3];
  wire         ovf_o [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NN = (g == 2) ? 32 : 16;
    localparam int SS = (g == 0) ? 4 : ((g == 1) ? 16 : 8);
    logic [NN-1:0] s;
    ripple_pipe_addsub #(.N(NN), .SEG(SS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_d[g]),
      .in_ready  (in_ready_o[g]),
      .a         (a_d[g][NN-1:0]),
      .b         (b_d[g][NN-1:0]),
      .cin       (cin_d[g]),
      .sub       (sub_d[g]),
      .out_valid (out_valid_o[g]),
      .out_ready (out_ready_d[g]),
      .sum       (s),
      .cout      (cout_o[g]),
      .ovf       (ovf_o[g])
    );
    assign sum_o[g] = 64'(s);
  end

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        o;
    int          stamp;
  } exp_t;

  exp_t        q[$];
  int          cur = 0;
  bit          chk_lat = 1'b0;
  bit          bp_mode = 1'b0;
  logic [63:0] nxt_s = '0;
  logic        nxt_c = 1'b0;
  logic        nxt_o = 1'b0;

  function automatic int lat_of(input int i);
    return (i == 1) ? 1 : 4;
  endfunction

  function automatic int width_of(input int i);
    return (i == 2) ? 32 : 16;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain wide arithmetic.
  function automatic logic [65:0] model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                        input logic ci, input logic su);
    logic [63:0] mask;
    logic [63:0] bb;
    logic [64:0] full;
    logic [63:0] s;
    logic        co;
    logic        ov;
    mask = (64'd1 << w) - 64'd1;
    bb   = (su ? ~bv : bv) & mask;
    full = {1'b0, av & mask} + {1'b0, bb} + 65'(su ? 1'b1 : ci);
    s    = full[63:0] & mask;
    co   = full[w];
    ov   = (av[w-1] == bb[w-1]) && (s[w-1] != av[w-1]);
    return {ov, co, s};
  endfunction

  logic        held = 1'b0;
  logic [63:0] held_s;
  logic        held_c;
  logic        held_o;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      chk("in_ready", in_ready_o[cur], !out_valid_o[cur] || out_ready_d[cur]);
      if (held) begin
        chk("hold_valid", out_valid_o[cur], 1);
        chk("hold_sum", sum_o[cur], held_s);
        chk("hold_cout", cout_o[cur], held_c);
        chk("hold_ovf", ovf_o[cur], held_o);
      end
      held   = out_valid_o[cur] && !out_ready_d[cur];
      held_s = sum_o[cur];
      held_c = cout_o[cur];
      held_o = ovf_o[cur];
      if (in_valid_d[cur] && in_ready_o[cur]) q.push_back('{nxt_s, nxt_c, nxt_o, cyc});
      if (out_valid_o[cur] && out_ready_d[cur]) begin
        chk("out_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("sum", sum_o[cur], e.s);
          chk("cout", cout_o[cur], e.c);
          chk("ovf", ovf_o[cur], e.o);
          if (chk_lat) chk("latency", cyc - e.stamp, lat_of(cur));
        end
      end
    end
  end

  // Present one operand set and hold it until accepted; call just after a rising edge.
  task automatic send(input int i, input logic [63:0] av, input logic [63:0] bv, input logic ci,
                      input logic su, input logic [63:0] es, input logic ec, input logic eo);
    int n;
    bit acc;
    a_d[i] = av; b_d[i] = bv; cin_d[i] = ci; sub_d[i] = su;
    nxt_s = es; nxt_c = ec; nxt_o = eo;
    in_valid_d[i] = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready_o[i];
      @(posedge clk);
      #1;
      n++;
      if (bp_mode) out_ready_d[i] = 1'($urandom_range(0, 1));
    end
    in_valid_d[i] = 1'b0;
    chk("accept", acc, 1);
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (bp_mode) out_ready_d[i] = 1'($urandom_range(0, 1));
    end
    out_ready_d[i] = 1'b1;
    chk("drain", q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [65:0] r;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;
    logic        rs;
    for (int i = 0; i < 3; i++) begin
      a_d[i] = '0; b_d[i] = '0; cin_d[i] = 1'b0; sub_d[i] = 1'b0;
      in_valid_d[i] = 1'b0; out_ready_d[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid_o[0], 0);
    chk("rst_sum", sum_o[0], 0);
    chk("rst_cout", cout_o[0], 0);
    chk("rst_ovf", ovf_o[0], 0);
    rst_n = 1'b1;
    chk("rdy_after_rst", in_ready_o[0], 1);

    // 1: full carry propagation
    cur = 0;
    chk_lat = 1'b1;
    send(0, 64'hFFFF, 64'h0001, 1'b0, 1'b0, 64'h0000, 1'b1, 1'b0);
    drain(0);

    // 2: back-to-back adds
    send(0, 64'h7FFF, 64'h0001, 1'b0, 1'b0, 64'h8000, 1'b0, 1'b1);
    send(0, 64'h1234, 64'h4321, 1'b0, 1'b0, 64'h5555, 1'b0, 1'b0);
    send(0, 64'h8000, 64'h8000, 1'b0, 1'b0, 64'h0000, 1'b1, 1'b1);
    drain(0);

    // 3: subtract with cin driven high
    send(0, 64'h0005, 64'h0007, 1'b1, 1'b1, 64'hFFFE, 1'b0, 1'b0);
    send(0, 64'h8000, 64'h0001, 1'b1, 1'b1, 64'h7FFF, 1'b1, 1'b1);
    drain(0);

    // 4: random ops under random backpressure
    chk_lat = 1'b0;
    bp_mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ra = 64'($urandom_range(0, 16'hFFFF));
      rb = 64'($urandom_range(0, 16'hFFFF));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      r  = model(width_of(0), ra, rb, rc, rs);
      send(0, ra, rb, rc, rs, r[63:0], r[64], r[65]);
    end
    drain(0);
    bp_mode = 1'b0;
    chk_lat = 1'b1;

    // 5: reset with three operations in flight
    out_ready_d[0] = 1'b0;
    send(0, 64'h1111, 64'h2222, 1'b0, 1'b0, 64'h3333, 1'b0, 1'b0);
    send(0, 64'h0101, 64'h0202, 1'b0, 1'b0, 64'h0303, 1'b0, 1'b0);
    send(0, 64'h7000, 64'h7000, 1'b0, 1'b0, 64'hE000, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", out_valid_o[0], 1);
    chk("pre_rst_sum", sum_o[0], 64'h3333);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid_o[0], 0);
    chk("midrst_sum", sum_o[0], 0);
    chk("midrst_cout", cout_o[0], 0);
    chk("midrst_ovf", ovf_o[0], 0);
    q.delete();
    out_ready_d[0] = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(0, 64'h0001, 64'h0001, 1'b0, 1'b0, 64'h0002, 1'b0, 1'b0);
    drain(0);

    // 6a: single-stage build, latency 1
    cur = 1;
    send(1, 64'hFFFF, 64'h0001, 1'b0, 1'b0, 64'h0000, 1'b1, 1'b0);
    drain(1);
    send(1, 64'h7FFF, 64'h0001, 1'b0, 1'b0, 64'h8000, 1'b0, 1'b1);
    send(1, 64'h1234, 64'h4321, 1'b0, 1'b0, 64'h5555, 1'b0, 1'b0);
    send(1, 64'h8000, 64'h8000, 1'b0, 1'b0, 64'h0000, 1'b1, 1'b1);
    drain(1);

    // 6b: 32-bit build in 8-bit segments, latency 4
    cur = 2;
    send(2, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    drain(2);
    send(2, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000, 1'b0, 1'b1);
    send(2, 64'h1234_5678, 64'h1111_1111, 1'b0, 1'b0, 64'h2345_6789, 1'b0, 1'b0);
    send(2, 64'h8000_0000, 64'h8000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
    drain(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ripple_pipe_addsub.md
Name: ripple_pipe_addsub

Overview:
- Parametrised, pipelined successor to the team's structural n-bit ripple-carry adder.
- Splits an N-bit add/subtract into STAGES segments of SEG bits. Each segment's carry is registered between stages, so the critical path is one SEG-bit ripple instead of N bits.
- Adds a valid/ready stream handshake with full backpressure, an add/subtract mode, and a signed-overflow flag.
- Used in datapaths whose clock rate cannot tolerate a full-width ripple chain.

Parameters:
- N, 16, operand width in bits; must be a multiple of SEG and at least 2.
- SEG, 4, bits added per pipeline stage; STAGES = N/SEG, with STAGES >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  an operand set is presented this cycle.
- in_ready  output  1  block accepts the operand set when in_valid && in_ready.
- a  input  N  operand A, unsigned or two's complement.
- b  input  N  operand B.
- cin  input  1  carry-in, used only when sub=0.
- sub  input  1  0 = A+B+cin; 1 = A-B (A + ~B + 1; cin ignored).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result when out_valid && out_ready.
- sum  output  N  result.
- cout  output  1  carry out of bit N-1. In subtract mode, 1 means no borrow.
- ovf  output  1  signed overflow: carry into bit N-1 XOR carry out of bit N-1.

Behaviour:
- Reset (rst_n low, asynchronous): every stage valid bit clears, out_valid=0, sum=0, cout=0, ovf=0. Data registers may clear to 0.
  - Effect is immediate, mid-operation included; in-flight results are discarded.
  - in_ready is 1 in the first cycle after reset release.
- Global stall: adv = !out_valid || out_ready; in_ready = adv (combinational).
  - When adv=0, no pipeline register changes. When adv=1, every stage shifts forward one position, bubbles included.
- Stage k (k = 0..STAGES-1) computes segment k: bits [k*SEG + SEG-1 : k*SEG].
  - Operands are A_k and B'_k, where B' = sub ? ~b : b.
  - Carry-in for stage 0 = sub ? 1 : cin. Carry-in for stage k>0 = the registered carry from stage k-1.
  - Each stage internally is a SEG-bit ripple chain of full adders.
- Input skew: segment k operands are delayed k register levels before stage k uses them. Completed lower result segments are delayed so that all N sum bits of one operation emerge together.
- Latency: STAGES cycles from accept to out_valid, with no stalls.
  - Throughput: one operation per cycle while out_ready=1.
  - STAGES=1: a single registered N-bit adder, latency 1.
- cout and ovf are registered together with the final segment and belong to the same operation as sum. ovf uses the internal carry into bit N-1.
- Ordering is strictly FIFO: no reordering or dropping.
- While out_valid=1 and out_ready=0, sum, cout and ovf hold stable.
- An operation is not accepted when in_valid=0. Bubbles travel as valid=0 stages and never raise out_valid.
- Simultaneous accept and drain in the same cycle is legal and loses nothing.
- in_ready depends combinationally on out_ready only (no path from in_valid).
- Widths: the sum wraps modulo 2^N; no saturation.

Test Plan (N=16, SEG=4, latency 4):
1. Reset, then a=16'hFFFF, b=16'h0001, cin=0, sub=0, out_ready=1, single beat.
   - Required: out_valid exactly 4 cycles later, sum=16'h0000, cout=1, ovf=0.
   - Checks full carry propagation across all stages.
2. Back-to-back, one per cycle, sub=0, cin=0:
   - 16'h7FFF+16'h0001 -> sum=16'h8000, cout=0, ovf=1.
   - 16'h1234+16'h4321 -> sum=16'h5555, cout=0, ovf=0.
   - 16'h8000+16'h8000 -> sum=16'h0000, cout=1, ovf=1.
   - All three results on consecutive cycles, in order.
3. Subtract: 16'h0005-16'h0007 -> sum=16'hFFFE, cout=0, ovf=0. Then 16'h8000-16'h0001 -> sum=16'h7FFF, cout=1, ovf=1. cin=1 is driven and must be ignored.
4. Backpressure: stream 8 random ops with out_ready toggling pseudo-randomly.
   - in_ready must equal !out_valid || out_ready.
   - Outputs must hold stable during stalls.
   - All 8 results must match a reference model, in order, with none lost or duplicated.
5. Reset mid-stream: drop rst_n with 3 ops in flight.
   - Required: out_valid=0 and sum/cout/ovf=0 immediately.
   - After release, a fresh op 16'h0001+16'h0001 yields 16'h0002 after 4 cycles, with no stale outputs.
6. Parameter sweep: rerun scenarios 1 and 2 with (N=16, SEG=16) for latency 1, and with (N=32, SEG=8) for latency 4, using width-adjusted all-ones+1 and max-positive+1 cases.
